lvds_link_monitor: RTL and testbench

LVDS_LINK_MONITOR -- requirements
Module: lvds_link_monitor

---
 rtl/lvds_link_monitor.sv | 175 +++++++++++++++++
 tb/tb_lvds_link_monitor.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_link_monitor.sv
// LVDS/SFP link monitor: stuck-line detection, frame-based lock FSM and errored-frame count.
// Optional macro LINK_MON_ERR_CNT_EN builds the saturating error counter; otherwise o_err_cnt is 0.
module lvds_link_monitor #(
    parameter int unsigned STUCK_LEN  = 64,
    parameter int unsigned LOCK_GOOD  = 16,
    parameter int unsigned UNLOCK_BAD = 4
) (
    input  logic        i_clk,
    input  logic        i_res,
    input  logic        i_sdat,
    input  logic        i_loss_sig,
    input  logic        i_frm_vld,
    input  logic        i_frm_err,
    input  logic        i_err_clr,
    output logic [1:0]  o_state,
    output logic        o_link_up,
    output logic        o_stuck_hi,
    output logic        o_stuck_lo,
    output logic        o_err_pulse,
    output logic [15:0] o_err_cnt
);

    typedef enum logic [1:0] {
        ST_LOST   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    logic        r_prev;
    logic [15:0] r_run;
    logic [15:0] w_run_nxt;
    logic        w_run_sat;
    logic        r_stuck_hi;
    logic        r_stuck_lo;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_good;
    logic [7:0]  r_bad;
    logic [7:0]  w_good_nxt;
    logic [7:0]  w_bad_nxt;
    logic        r_link_up;
    logic        r_err_pulse;
    logic        w_good_frm;
    logic        w_bad_frm;
    logic        w_fault;

    assign w_good_frm = i_frm_vld & ~i_frm_err;
    assign w_bad_frm  = i_frm_vld & i_frm_err;
    assign w_fault    = i_loss_sig | r_stuck_hi | r_stuck_lo;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_run_nxt = r_run;
        if (i_sdat != r_prev) begin
            w_run_nxt = 16'd0;
        end else if (r_run != 16'(STUCK_LEN)) begin
            w_run_nxt = r_run + 16'd1;
        end
    end

    // STUCK_LEN >= 2 means a saturated count implies no edge this cycle, so i_sdat is the held level.
    assign w_run_sat = (w_run_nxt == 16'(STUCK_LEN));

    // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_prev      <= 1'b0;
            r_run       <= 16'd0;
            r_stuck_hi  <= 1'b0;
            r_stuck_lo  <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_prev      <= i_sdat;
            r_run       <= w_run_nxt;
            r_stuck_hi  <= w_run_sat & i_sdat;
            r_stuck_lo  <= w_run_sat & ~i_sdat;
            r_err_pulse <= w_bad_frm;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        unique case (r_state)
            ST_LOST: begin
                w_good_nxt = 8'd0;
                w_bad_nxt  = 8'd0;
                if (!w_fault) begin
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (w_fault) begin
                    w_state_nxt = ST_LOST;
                    w_good_nxt  = 8'd0;
                    w_bad_nxt   = 8'd0;
                end else if (w_good_frm) begin
                    if (r_good + 8'd1 == 8'(LOCK_GOOD)) begin
                        w_state_nxt = ST_LOCKED;
                        w_good_nxt  = 8'd0;
                        w_bad_nxt   = 8'd0;
                    end else begin
                        w_good_nxt = r_good + 8'd1;
                    end
                end else if (w_bad_frm) begin
                    w_good_nxt = 8'd0;
                end
            end
            ST_LOCKED: begin
                if (w_fault) begin
                    w_state_nxt = ST_LOST;
                    w_good_nxt  = 8'd0;
                    w_bad_nxt   = 8'd0;
                end else if (w_bad_frm) begin
                    if (r_bad + 8'd1 == 8'(UNLOCK_BAD)) begin
                        w_state_nxt = ST_HUNT;
                        w_good_nxt  = 8'd0;
                        w_bad_nxt   = 8'd0;
                    end else begin
                        w_bad_nxt = r_bad + 8'd1;
                    end
                end else if (w_good_frm) begin
                    w_bad_nxt = 8'd0;
                end
            end
            default: begin
                w_state_nxt = ST_LOST;
                w_good_nxt  = 8'd0;
                w_bad_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_state   <= ST_LOST;
            r_good    <= 8'd0;
            r_bad     <= 8'd0;
            r_link_up <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_good    <= w_good_nxt;
            r_bad     <= w_bad_nxt;
            r_link_up <= (w_state_nxt == ST_LOCKED);
        end
    end

`ifdef LINK_MON_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Count uses the state the frame arrived in, so an error coincident with loss in LOCKED still counts.
    always_ff @(posedge i_clk) begin
        if (i_res || i_err_clr) begin
            r_err_cnt <= 16'd0;
        end else if (w_bad_frm && (r_state != ST_LOST) && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = i_err_clr;
    assign o_err_cnt        = 16'h0000;
`endif

    assign o_state     = r_state;
    assign o_link_up   = r_link_up;
    assign o_stuck_hi  = r_stuck_hi;
    assign o_stuck_lo  = r_stuck_lo;
    assign o_err_pulse = r_err_pulse;

endmodule

// File: tb/tb_lvds_link_monitor.sv
// Directed bench for lvds_link_monitor (default parameters); expected error count follows LINK_MON_ERR_CNT_EN.
module tb_lvds_link_monitor;

    logic        clk = 1'b0;
    logic        res;
    logic        sdat;
    logic        loss_sig;
    logic        frm_vld;
    logic        frm_err;
    logic        err_clr;
    logic [1:0]  state;
    logic        link_up;
    logic        stuck_hi;
    logic        stuck_lo;
    logic        err_pulse;
    logic [15:0] err_cnt;

    int          n_vec = 0;
    int          n_bad = 0;
    bit          tog   = 1'b0;
    logic [15:0] exp_cnt = 16'd0;

    lvds_link_monitor dut (
        .i_clk      (clk),
        .i_res      (res),
        .i_sdat     (sdat),
        .i_loss_sig (loss_sig),
        .i_frm_vld  (frm_vld),
        .i_frm_err  (frm_err),
        .i_err_clr  (err_clr),
        .o_state    (state),
        .o_link_up  (link_up),
        .o_stuck_hi (stuck_hi),
        .o_stuck_lo (stuck_lo),
        .o_err_pulse(err_pulse),
        .o_err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cnt_exp();
`ifdef LINK_MON_ERR_CNT_EN
        return exp_cnt;
`else
        return 16'h0000;
`endif
    endfunction

    // Model of one errored frame seen in HUNT or LOCKED.
    task automatic err_seen();
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    // One clock: present a frame strobe, step past the edge, then advance the line pattern.
    task automatic cyc(input logic vld, input logic err);
        frm_vld = vld;
        frm_err = err;
        @(posedge clk);
        #1;
        frm_vld = 1'b0;
        frm_err = 1'b0;
        if (tog) sdat = ~sdat;
    endtask

    task automatic check_link(input string tag, input logic [1:0] st, input logic up);
        check({tag, ".state"}, state, st);
        check({tag, ".link_up"}, link_up, up);
        check({tag, ".err_cnt"}, err_cnt, cnt_exp());
    endtask

    task automatic lock(input string tag);
        repeat (15) cyc(1'b1, 1'b0);
        check({tag, ".15th"}, state, 2'd1);
        cyc(1'b1, 1'b0);
        check_link({tag, ".16th"}, 2'd2, 1'b1);
    endtask

    task automatic stuck_test(input string tag, input logic lvl, input int hold);
        if (sdat != lvl) cyc(1'b0, 1'b0);
        tog = 1'b0;
        repeat (64) cyc(1'b0, 1'b0);
        check({tag, ".pre_flags"}, {stuck_hi, stuck_lo}, 2'b00);
        check({tag, ".pre_state"}, state, 2'd2);
        cyc(1'b0, 1'b0);
        check({tag, ".flags"}, {stuck_hi, stuck_lo}, {lvl, ~lvl});
        check({tag, ".still_locked"}, state, 2'd2);
        cyc(1'b0, 1'b0);
        check_link({tag, ".lost"}, 2'd0, 1'b0);
        repeat (hold) cyc(1'b0, 1'b0);
        check({tag, ".held_flags"}, {stuck_hi, stuck_lo}, {lvl, ~lvl});
        check({tag, ".held_state"}, state, 2'd0);
        sdat = ~lvl;
        tog  = 1'b1;
        cyc(1'b0, 1'b0);
        check({tag, ".clear_flags"}, {stuck_hi, stuck_lo}, 2'b00);
        check({tag, ".clear_state"}, state, 2'd0);
        cyc(1'b0, 1'b0);
        check({tag, ".hunt"}, state, 2'd1);
        lock({tag, ".relock"});
    endtask

    initial begin
        res      = 1'b1;
        sdat     = 1'b0;
        loss_sig = 1'b0;
        frm_vld  = 1'b0;
        frm_err  = 1'b0;
        err_clr  = 1'b0;
        repeat (3) cyc(1'b0, 1'b0);
        check_link("reset", 2'd0, 1'b0);
        check("reset.flags", {stuck_hi, stuck_lo, err_pulse}, 3'b000);

        // Bring-up: LOST -> HUNT -> LOCKED on the 16th good strobe.
        res = 1'b0;
        tog = 1'b1;
        cyc(1'b0, 1'b0);
        check("bringup.hunt", state, 2'd1);
        lock("bringup");

        // Single bad frame in LOCKED.
        cyc(1'b1, 1'b1);
        err_seen();
        check("bad1.pulse", err_pulse, 1'b1);
        check_link("bad1", 2'd2, 1'b1);
        cyc(1'b1, 1'b0);
        check("bad1.pulse_end", err_pulse, 1'b0);
        check_link("bad1.after", 2'd2, 1'b1);

        // 3 bad / 1 good interleave keeps the lock.
        repeat (2) begin
            repeat (3) begin
                cyc(1'b1, 1'b1);
                err_seen();
            end
            check("ilv.after3", state, 2'd2);
            cyc(1'b1, 1'b0);
        end
        check_link("ilv.end", 2'd2, 1'b1);

        // Four consecutive bad frames drop to HUNT.
        repeat (3) begin
            cyc(1'b1, 1'b1);
            err_seen();
        end
        check("unlock.after3", state, 2'd2);
        cyc(1'b1, 1'b1);
        err_seen();
        check_link("unlock.after4", 2'd1, 1'b0);
        lock("unlock.relock");

        stuck_test("stuck_hi", 1'b1, 4000);
        stuck_test("stuck_lo", 1'b0, 300);

        // Loss together with a bad strobe: LOST wins, pulse still fires, LOCKED error counted.
        loss_sig = 1'b1;
        cyc(1'b1, 1'b1);
        err_seen();
        check("loss.pulse", err_pulse, 1'b1);
        check_link("loss", 2'd0, 1'b0);
        cyc(1'b1, 1'b1);
        check("lost_err.pulse", err_pulse, 1'b1);
        check_link("lost_err", 2'd0, 1'b0);
        loss_sig = 1'b0;
        cyc(1'b0, 1'b0);
        check("loss.recover", state, 2'd1);
        check("loss.pulse_end", err_pulse, 1'b0);

        err_clr = 1'b1;
        cyc(1'b0, 1'b0);
        err_clr = 1'b0;
        exp_cnt = 16'd0;
        check("clr", err_cnt, cnt_exp());

`ifdef LINK_MON_ERR_CNT_EN
        repeat (65534) begin
            cyc(1'b1, 1'b1);
            err_seen();
        end
        check("sat.fffe", err_cnt, 16'hFFFE);
        cyc(1'b1, 1'b1);
        err_seen();
        check("sat.ffff", err_cnt, 16'hFFFF);
        repeat (2) begin
            cyc(1'b1, 1'b1);
            err_seen();
        end
        check("sat.hold", err_cnt, 16'hFFFF);
`endif

        // Clear coincident with an errored frame.
        err_clr = 1'b1;
        cyc(1'b1, 1'b1);
        err_clr = 1'b0;
        exp_cnt = 16'd0;
        check("clr_err.cnt", err_cnt, cnt_exp());
        check("clr_err.pulse", err_pulse, 1'b1);
        cyc(1'b1, 1'b1);
        err_seen();
        check("clr_err.next", err_cnt, cnt_exp());
        check("clr_err.hunt", state, 2'd1);

        // Reset while LOCKED, with a bad strobe in the reset cycle.
        lock("prereset");
        res  = 1'b1;
        tog  = 1'b0;
        sdat = 1'b0;
        cyc(1'b1, 1'b1);
        exp_cnt = 16'd0;
        check_link("mid_reset", 2'd0, 1'b0);
        check("mid_reset.flags", {stuck_hi, stuck_lo, err_pulse}, 3'b000);
        cyc(1'b0, 1'b0);
        res = 1'b0;

        // Run-length restarts from 0: line held low since reset flags stuck_lo 64 cycles later.
        cyc(1'b0, 1'b0);
        check("rst_run.hunt", state, 2'd1);
        repeat (62) cyc(1'b0, 1'b0);
        check("rst_run.pre", {stuck_hi, stuck_lo}, 2'b00);
        cyc(1'b0, 1'b0);
        check("rst_run.lo", {stuck_hi, stuck_lo}, 2'b01);
        check("rst_run.state", state, 2'd1);
        cyc(1'b0, 1'b0);
        check_link("rst_run.lost", 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
